// File: rtl/control_c_pingpong.sv
// ============================================================================
// control_c_pingpong : two-bank C-tile buffer between the PE array (fill) and
// the result-drain stream (valid/ready). Optional k-pass accumulate: C_ACCUM_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_c_pingpong #(
  parameter int DATA_W = 64,
  parameter int LANES  = 2,
  parameter int DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             n_in,
  input  logic [7:0]              kpass_in,
  input  logic                    store_valid_in,
  input  logic [LANES*DATA_W-1:0] store_data_in,
  output logic                    store_ready_out,
  output logic                    load_valid_out,
  output logic [LANES*DATA_W-1:0] load_data_out,
  output logic                    load_last_out,
  input  logic                    load_ready_in,
  output logic [1:0]              bank_full_out
);

  localparam int W      = LANES * DATA_W;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   N_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   N_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_FILLING = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0][1:0]    st_q, st_d;
  logic               wr_bank_q, rd_bank_q;
  logic [ADDR_W-1:0]  wr_addr_q, rd_addr_q;
  logic [7:0]         pass_q;
  logic [1:0][ADDR_W:0] nlat_q;
  logic               rd_done_q;
  logic               load_valid_q, load_last_q;
  logic [W-1:0]       load_data_q;
  logic [W-1:0]       mem_q [2*DEPTH];

  logic [ADDR_W:0]    w_n_clamp, w_n_eff;
  logic [7:0]         w_k_eff;
  logic               w_wr_empty, w_store, w_wrap, w_final;
  logic [1:0]         w_rd_st;
  logic               w_issue, w_rd_last, w_hs_last;
  logic               w_full_evt, w_full_bank;

  assign w_n_clamp  = (n_in == 32'd0 || n_in > 32'(DEPTH)) ? N_DEPTH : n_in[ADDR_W:0];
  assign w_wr_empty = (st_q[wr_bank_q] == S_EMPTY);
  // Tile length comes straight from n_in on the first beat, from the latch after.
  assign w_n_eff    = w_wr_empty ? w_n_clamp : nlat_q[wr_bank_q];

  assign store_ready_out = (st_q[wr_bank_q] == S_EMPTY) || (st_q[wr_bank_q] == S_FILLING);
  assign w_store = store_valid_in && store_ready_out;
  assign w_wrap  = ({1'b0, wr_addr_q} == w_n_eff - N_ONE);
  assign w_final = w_wrap && (pass_q == w_k_eff - 8'd1);

  assign w_rd_st   = st_q[rd_bank_q];
  assign w_issue   = ((w_rd_st == S_FULL) || (w_rd_st == S_DRAIN && !rd_done_q)) &&
                     (!load_valid_q || load_ready_in);
  assign w_rd_last = ({1'b0, rd_addr_q} == nlat_q[rd_bank_q] - N_ONE);
  assign w_hs_last = load_valid_q && load_ready_in && load_last_q;

`ifdef C_ACCUM_EN
  logic [1:0][7:0]   klat_q;
  logic [7:0]        w_k_clamp;
  logic              s1_valid_q, s1_acc_q, s1_final_q, s1_bank_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [W-1:0]      s1_data_q, old_q, w_sum, w_wdata;

  assign w_k_clamp   = (kpass_in == 8'd0) ? 8'd1 : kpass_in;
  assign w_k_eff     = w_wr_empty ? w_k_clamp : klat_q[wr_bank_q];
  assign w_full_evt  = s1_valid_q && s1_final_q;
  assign w_full_bank = s1_bank_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_sum[l*DATA_W +: DATA_W] = old_q[l*DATA_W +: DATA_W] + s1_data_q[l*DATA_W +: DATA_W];
  end
  assign w_wdata = s1_acc_q ? w_sum : s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_final_q <= 1'b0;
      s1_bank_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      klat_q     <= '0;
    end else begin
      s1_valid_q <= w_store;
      s1_acc_q   <= (pass_q != 8'd0);
      s1_final_q <= w_final;
      s1_bank_q  <= wr_bank_q;
      s1_addr_q  <= wr_addr_q;
      s1_data_q  <= store_data_in;
      if (w_store && w_wr_empty) klat_q[wr_bank_q] <= w_k_clamp;
    end
  end

  // Forward the sum being written this edge so same-address beats chain correctly.
  always_ff @(posedge clk) begin
    if (s1_valid_q && {s1_bank_q, s1_addr_q} == {wr_bank_q, wr_addr_q})
      old_q <= w_wdata;
    else
      old_q <= mem_q[{wr_bank_q, wr_addr_q}];
    if (s1_valid_q) mem_q[{s1_bank_q, s1_addr_q}] <= w_wdata;
  end
`else
  logic unused_kpass;
  assign unused_kpass = ^kpass_in;
  assign w_k_eff      = 8'd1;
  assign w_full_evt   = w_store && w_final;
  assign w_full_bank  = wr_bank_q;

  always_ff @(posedge clk) begin
    if (w_store) mem_q[{wr_bank_q, wr_addr_q}] <= store_data_in;
  end
`endif

  always_comb begin
    st_d = st_q;
    if (w_store && w_wr_empty) st_d[wr_bank_q] = S_FILLING;
    if (w_full_evt) st_d[w_full_bank] = S_FULL;
    if (w_issue && w_rd_st == S_FULL) st_d[rd_bank_q] = S_DRAIN;
    if (w_hs_last) st_d[rd_bank_q] = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pass_q       <= 8'd0;
      nlat_q       <= '0;
      rd_done_q    <= 1'b0;
      load_valid_q <= 1'b0;
      load_last_q  <= 1'b0;
      load_data_q  <= '0;
    end else begin
      st_q <= st_d;
      if (w_store) begin
        if (w_wr_empty) nlat_q[wr_bank_q] <= w_n_clamp;
        if (w_wrap) begin
          wr_addr_q <= '0;
          pass_q    <= w_final ? 8'd0 : pass_q + 8'd1;
        end else begin
          wr_addr_q <= wr_addr_q + A_ONE;
        end
        if (w_final) wr_bank_q <= ~wr_bank_q;
      end
      if (w_issue) begin
        load_valid_q <= 1'b1;
        load_data_q  <= mem_q[{rd_bank_q, rd_addr_q}];
        load_last_q  <= w_rd_last;
        if (w_rd_last) rd_done_q <= 1'b1;
        else           rd_addr_q <= rd_addr_q + A_ONE;
      end else if (load_valid_q && load_ready_in) begin
        load_valid_q <= 1'b0;
      end
      if (w_hs_last) begin
        rd_bank_q <= ~rd_bank_q;
        rd_addr_q <= '0;
        rd_done_q <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_full_out[b] = (st_q[b] == S_FULL) || (st_q[b] == S_DRAIN);
  end

  assign load_valid_out = load_valid_q;
  assign load_data_out  = load_data_q;
  assign load_last_out  = load_last_q;

endmodule

`default_nettype wire

// File: tb/tb_control_c_pingpong.sv
// ============================================================================
// tb_control_c_pingpong : directed bench with a tile-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_c_pingpong;

  localparam int W = 128;
`ifdef C_ACCUM_EN
  localparam int LAT = 1;
  localparam bit ACC = 1'b1;
`else
  localparam int LAT = 0;
  localparam bit ACC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   n_in = 32'd4;
  logic [7:0]    kpass_in = 8'd1;
  logic          store_valid_in = 1'b0;
  logic [W-1:0]  store_data_in = '0;
  logic          store_ready_out;
  logic          load_valid_out;
  logic [W-1:0]  load_data_out;
  logic          load_last_out;
  logic          load_ready_in = 1'b0;
  logic [1:0]    bank_full_out;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int hs_cnt = 0;
  int h0;
  logic [W-1:0] last_hs_data = '0;

  // reference model: per-tile accumulation image and expected drain stream
  logic [W-1:0] exp_data[$];
  logic         exp_last[$];
  logic [W-1:0] m_acc [64];
  int m_active = 0, m_n = 0, m_k = 0, m_pass = 0, m_addr = 0;

  always #5 clk = ~clk;

  control_c_pingpong dut (
    .clk             (clk),
    .rst             (rst),
    .n_in            (n_in),
    .kpass_in        (kpass_in),
    .store_valid_in  (store_valid_in),
    .store_data_in   (store_data_in),
    .store_ready_out (store_ready_out),
    .load_valid_out  (load_valid_out),
    .load_data_out   (load_data_out),
    .load_last_out   (load_last_out),
    .load_ready_in   (load_ready_in),
    .bank_full_out   (bank_full_out)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a[127:64] + b[127:64], a[63:0] + b[63:0]};
  endfunction

  task automatic model_accept(input logic [W-1:0] d);
    if (m_active == 0) begin
      m_n = (n_in == 0 || n_in > 64) ? 64 : int'(n_in);
      m_k = ACC ? ((kpass_in == 0) ? 1 : int'(kpass_in)) : 1;
      m_pass = 0;
      m_addr = 0;
      m_active = 1;
    end
    m_acc[m_addr] = (m_pass == 0) ? d : lane_add(m_acc[m_addr], d);
    if (m_addr == m_n - 1) begin
      m_addr = 0;
      m_pass++;
      if (m_pass == m_k) begin
        for (int j = 0; j < m_n; j++) begin
          exp_data.push_back(m_acc[j]);
          exp_last.push_back(j == m_n - 1);
        end
        m_active = 0;
      end
    end else begin
      m_addr++;
    end
  endtask

  task automatic model_reset();
    exp_data.delete();
    exp_last.delete();
    m_active = 0;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [W-1:0] d);
    int g = 0;
    store_valid_in = 1'b1;
    store_data_in  = d;
    while (!store_ready_out && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!store_ready_out) begin
      checks++;
      errors++;
      $display("FAIL store_timeout: store_ready_out stayed %0b, required 1", store_ready_out);
      store_valid_in = 1'b0;
      return;
    end
    model_accept(d);
    @(negedge clk);
    store_valid_in = 1'b0;
  endtask

  task automatic wait_drained();
    int g = 0;
    while ((exp_data.size() != 0 || m_active != 0 || load_valid_out) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_data.size());
    end
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       load_ready_in = 1'b0;
      1:       load_ready_in = 1'b1;
      default: load_ready_in = ~load_ready_in;
    endcase
  end

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  logic [W-1:0] mon_d;
  logic         mon_l;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", W'(load_valid_out), W'(1'b1));
        check("stall_data", load_data_out, prev_data);
        check("stall_last", W'(load_last_out), W'(prev_last));
      end
      if (load_valid_out && load_ready_in) begin
        hs_cnt++;
        last_hs_data = load_data_out;
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", load_data_out);
        end else begin
          mon_d = exp_data.pop_front();
          mon_l = exp_last.pop_front();
          check("drain_data", load_data_out, mon_d);
          check("drain_last", W'(load_last_out), W'(mon_l));
        end
      end
      prev_stall = load_valid_out && !load_ready_in;
      prev_data  = load_data_out;
      prev_last  = load_last_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_store_ready", W'(store_ready_out), W'(1'b1));
    check("rst_load_valid", W'(load_valid_out), W'(1'b0));
    check("rst_load_data", load_data_out, '0);
    check("rst_load_last", W'(load_last_out), W'(1'b0));
    check("rst_bank_full", W'(bank_full_out), W'(2'b00));

    // single tile, n=4, drain latency
    n_in = 32'd4;
    ready_mode = 1;
    for (int i = 1; i <= 4; i++) push({64'(i + 100), 64'(i)});
    repeat (LAT) @(negedge clk);
    check("t1_full_bit", W'(bank_full_out), W'(2'b01));
    check("t1_valid_early", W'(load_valid_out), W'(1'b0));
    @(negedge clk);
    check("t1_valid_first", W'(load_valid_out), W'(1'b1));
    check("t1_first_data", load_data_out, {64'd101, 64'd1});
    wait_drained();
    check("t1_bank_empty", W'(bank_full_out), W'(2'b00));
    check("t1_ready_after", W'(store_ready_out), W'(1'b1));

    // both banks fill while drain is blocked
    ready_mode = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 1; i <= 12; i++) push({64'(i + 200), 64'(i)});
      end
      begin
        repeat (12) @(negedge clk);
        check("t2_both_full", W'(bank_full_out), W'(2'b11));
        check("t2_store_stall", W'(store_ready_out), W'(1'b0));
        ready_mode = 1;
      end
    join
    wait_drained();

    // toggling ready
    ready_mode = 2;
    n_in = 32'd3;
    for (int i = 0; i < 6; i++) push({$urandom, $urandom, $urandom, $urandom});
    wait_drained();

    // length clamping and mid-tile n_in changes
    ready_mode = 1;
    n_in = 32'd0;
    h0 = hs_cnt;
    for (int i = 0; i < 64; i++) push({64'(i), 64'(i * 3)});
    wait_drained();
    check("t4_n0_len", W'(hs_cnt - h0), W'(64));
    n_in = 32'd100;
    h0 = hs_cnt;
    for (int i = 0; i < 64; i++) push({64'(i + 7), 64'(i)});
    wait_drained();
    check("t4_n100_len", W'(hs_cnt - h0), W'(64));
    n_in = 32'd5;
    h0 = hs_cnt;
    push({64'd1, 64'd11});
    n_in = 32'd2;
    for (int i = 2; i <= 5; i++) push({64'(i), 64'(i + 10)});
    wait_drained();
    check("t4_midchange_len", W'(hs_cnt - h0), W'(5));
    check("t4_midchange_last", last_hs_data, {64'd5, 64'd15});

    // k-pass behaviour
    n_in = 32'd1;
    kpass_in = 8'd3;
    h0 = hs_cnt;
`ifdef C_ACCUM_EN
    push({64'd5, 64'd5});
    push({64'd6, 64'd6});
    push({64'd7, 64'd7});
    wait_drained();
    check("t5_accum_len", W'(hs_cnt - h0), W'(1));
    check("t5_accum_sum", last_hs_data, {64'd18, 64'd18});
    kpass_in = 8'd2;
    push({64'd3, 64'hFFFF_FFFF_FFFF_FFFF});
    push({64'd4, 64'd2});
    wait_drained();
    check("t5_accum_wrap", last_hs_data, {64'd7, 64'd1});
`else
    push({64'd9, 64'd5});
    wait_drained();
    check("t5_kpass_ignored_len", W'(hs_cnt - h0), W'(1));
    check("t5_kpass_ignored_data", last_hs_data, {64'd9, 64'd5});
`endif
    kpass_in = 8'd1;

    // reset while draining bank 0 and filling bank 1
    ready_mode = 0;
    n_in = 32'd4;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) push({64'(i + 300), 64'(i)});
    ready_mode = 1;
    repeat (3 + LAT) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_rst_valid", W'(load_valid_out), W'(1'b0));
    check("t6_rst_data", load_data_out, '0);
    check("t6_rst_last", W'(load_last_out), W'(1'b0));
    check("t6_rst_bank_full", W'(bank_full_out), W'(2'b00));
    check("t6_rst_ready", W'(store_ready_out), W'(1'b1));
    rst = 1'b0;
    @(negedge clk);
    n_in = 32'd2;
    h0 = hs_cnt;
    push({64'd41, 64'd40});
    push({64'd43, 64'd42});
    wait_drained();
    check("t6_post_len", W'(hs_cnt - h0), W'(2));
    check("t6_post_last", last_hs_data, {64'd43, 64'd42});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
